// File: rtl/id_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_seq_pkg
// Description : Shared types and constants for the ID digit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package id_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
// Module      : tick_div
// Description : DIV-cycle prescaler with enable and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_seq_ctrl
// Description : Programmable digit-sequence player; SEG7_EN adds a seg output.
// Revision    : 1.0 - initial release
// ============================================================================
module id_seq_ctrl
    import id_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [idx_w(DEPTH)-1:0]   wr_addr,
    input  logic [3:0]                wr_data,
    input  logic [idx_w(DEPTH):0]     len,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      step,
    input  logic                      loop_en,
    output logic [3:0]                id,
    output logic                      id_valid,
    output logic [idx_w(DEPTH)-1:0]   idx,
    output logic                      busy,
    output logic                      done
`ifdef SEG7_EN
    ,
    output logic [6:0]                seg
`endif
);

    localparam int AW = idx_w(DEPTH);
    localparam int LW = AW + 1;

    state_e        state_q, state_d;
    logic [3:0]    table_q [DEPTH];
    logic [3:0]    table_d [DEPTH];
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    id_q, id_d;
    logic [LW-1:0] len_q, len_d;

    logic          tick;
    logic          last;
    logic [AW-1:0] next_idx;
    logic [3:0]    next_id;
    logic [3:0]    first_id;
    logic          len_ok;
    logic          adv;

    // Counter holds its count in HOLD and restarts on every entry to RUN
    tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .en    ((state_q == RUN) && !stop),
        .clr   ((state_q == IDLE) || (state_q == FINISH) ||
                ((state_q == HOLD) && start && !stop)),
        .tick  (tick)
    );

    // Reads bypass a same-cycle write so the new digit shows on the advance
    always_comb begin
        last     = ({1'b0, idx_q} == (len_q - 1'b1));
        next_idx = last ? '0 : idx_q + 1'b1;
        next_id  = (wr_en && (wr_addr == next_idx)) ? wr_data : table_q[next_idx];
        first_id = (wr_en && (wr_addr == '0)) ? wr_data : table_q[0];
        len_ok   = (len != '0) && (len <= LW'(DEPTH));
    end

    always_comb begin
        table_d = table_q;
        if (wr_en && ({1'b0, wr_addr} < LW'(DEPTH))) begin
            table_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        id_d    = id_q;
        len_d   = len_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && start && len_ok) begin
                    len_d   = len;
                    idx_d   = '0;
                    id_d    = first_id;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop)      state_d = HOLD;
                else if (tick) adv     = 1'b1;
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    adv = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (last && !loop_en) begin
                state_d = FINISH;
            end else begin
                idx_d = next_idx;
                id_d  = next_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            table_q <= '{default: '0};
            idx_q   <= '0;
            id_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            len_q   <= len_d;
        end
    end

    assign id       = id_q;
    assign idx      = idx_q;
    assign id_valid = (state_q == RUN) || (state_q == HOLD);
    assign busy     = id_valid;
    assign done     = (state_q == FINISH);

`ifdef SEG7_EN
    assign seg = id_valid ? SEG7_LUT[id_q] : SEG7_BLANK;
`endif

endmodule
`default_nettype wire

// File: doc/id_seq_ctrl.md
Name: id_seq_ctrl

Overview:
Sequencer that plays back a programmable student-ID digit sequence, one 4-bit digit per step. It holds a small digit table, loaded by the host, and steps through it at a prescaled rate. Supports run, pause, single-step and loop/once modes, and feeds the digit display path in place of a hard-wired next-state counter.

Parameters:
DEPTH, 8, number of digit-table entries (2..16)
DIV, 4, clock cycles per automatic step (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
wr_en  input  1  write wr_data into table[wr_addr] this cycle
wr_addr  input  $clog2(DEPTH)  table write address
wr_data  input  4  digit to write
len  input  $clog2(DEPTH)+1  active entry count; sampled on accepted start from IDLE
start  input  1  pulse: begin from IDLE, or resume from HOLD
stop  input  1  pulse: pause from RUN, or abort from HOLD
step  input  1  pulse: advance one entry while in HOLD
loop_en  input  1  1 = wrap after last entry, 0 = finish; sampled at each end-of-sequence
id  output  4  current digit (registered)
id_valid  output  1  id is meaningful (RUN or HOLD)
idx  output  $clog2(DEPTH)  current table index
busy  output  1  state is RUN or HOLD
done  output  1  one-cycle pulse at end of a non-looping sequence

Behaviour:
- Reset (asynchronous assert, synchronous to clk on release):
  - state=IDLE; id=0, id_valid=0, idx=0, busy=0, done=0.
  - Table cleared to 0; prescaler cleared.
- States: IDLE, RUN, HOLD, FINISH. Event priority per cycle: stop > start > step.
- IDLE:
  - start with 1<=len<=DEPTH: latch len_q=len, idx=0, id=table[0], id_valid=1, prescaler=0, go RUN.
  - Outputs are valid the cycle after start.
  - start with len=0 or len>DEPTH: ignored, stay IDLE.
  - stop and step: ignored.
- RUN:
  - Prescaler counts 0..DIV-1; tick when count==DIV-1. First advance occurs DIV cycles after entry.
  - On tick with idx<len_q-1: idx+1, and id=table[idx+1].
  - On tick with idx==len_q-1:
    - loop_en=1: idx=0, id=table[0].
    - loop_en=0: go FINISH.
  - stop: go HOLD; id and idx frozen, id_valid stays 1; prescaler frozen.
  - start while in RUN: ignored.
- HOLD:
  - step: apply one advance with the same wrap/finish rules as a tick; stay HOLD unless finishing.
  - start: go RUN with prescaler cleared to 0.
  - stop: abort to IDLE; id_valid=0, idx=0, done not asserted.
- FINISH: id_valid=0, busy=0, done=1 for exactly one cycle, then IDLE. id keeps its last value.
- Writes:
  - Accepted in any state.
  - A write to the entry currently displayed does not change id until the next advance.
  - A write to the entry being advanced to in the same cycle is bypassed: id takes wr_data.
- DIV=1: advance every cycle in RUN.
- len_q is not affected by len changes after start.

Optional Feature:
SEG7_EN:
- Defined: adds output seg [6:0], active-low segments {g,f,e,d,c,b,a}.
  - Combinational hex decode (0-F) of id; zero added latency.
  - seg=7'h7F (all off) when id_valid=0.
- Undefined: seg port and decoder are absent; all other behaviour is identical.

Decomposition:
- Package id_seq_pkg:
  - state typedef enum {IDLE, RUN, HOLD, FINISH}
  - 16-entry seg7 lookup constant
  - localparam helpers for index width
- Sub-module tick_div: DIV-cycle prescaler with enable and synchronous clear; outputs a tick pulse.

Test Plan:
- Write table {2,0,1,7}, len=4, loop_en=0, DIV=4, start -> id 2,0,1,7, each held 4 cycles; done pulses 1 cycle after the last hold; busy=0, id_valid=0 after.
- Same table with loop_en=1 -> sequence 2,0,1,7,2,0,... and done never asserted; then stop -> id frozen; start -> resume, next advance 4 cycles later.
- HOLD with idx=3 (last entry), loop_en=0, step -> FINISH, done=1 for one cycle, then IDLE.
- start with len=0, then with len=DEPTH+1 -> state stays IDLE, id_valid=0.
- During RUN, write wr_addr=next index on the tick cycle with wr_data=9 -> id=9 on advance; assert reset mid-RUN -> all outputs 0 immediately.
- SEG7_EN defined, id=8 -> seg=7'h00; id_valid=0 -> seg=7'h7F.
